// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame controller: FSM state encoding and the
// mode-0 SCLK idle level.
package spi_pkg;

    typedef enum logic [2:0] {
        PWR_RST  = 3'd0,
        PWR_WAIT = 3'd1,
        IDLE     = 3'd2,
        CS_OFF   = 3'd3,
        SETUP    = 3'd4,
        SCK_HI   = 3'd5,
        SCK_LO   = 3'd6,
        HOLD     = 3'd7
    } spi_state_t;

    localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_half_period_tick.sv
// SCLK half-period timer: reloads with the divider on every FSM state entry and
// raises o_tick on the last clk cycle of the half-period.
module spi_half_period_tick #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_div;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Loaded with div, so the state lasts div+1 cycles before the tick.
    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 master: display power-on reset sequencing, per-word D/C, CS hold
// across bursts. Define SPI_RX_EN to add spi_miso / rx_data capture.
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 2,
    parameter int CS_W       = 1,
    parameter int DIV_W      = 8,
    parameter int RST_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   tx_cs,
    input  logic              tx_dc,
    input  logic              tx_last,
    output logic              done,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic [NUM_CS-1:0] spi_cs_n,
    output logic              spi_dc,
    output logic              disp_rst_n
`ifdef SPI_RX_EN
    ,
    input  logic              spi_miso,
    output logic [DATA_W-1:0] rx_data
`endif
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int RC_W  = $clog2(RST_CYCLES + 1);

    spi_state_t        r_state;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [DATA_W-1:0] r_tx;
    logic [CS_W-1:0]   r_cs;
    logic              r_dc_q;
    logic              r_last;
    logic [DIV_W-1:0]  r_div;
    logic              r_held;
    logic [BIT_W-1:0]  r_bit;
    logic              r_ready, r_done, r_busy, r_sclk, r_mosi, r_dc, r_disp_rst_n;
    logic [NUM_CS-1:0] r_cs_n;

    logic             w_tick, w_load, w_accept, w_bits_done, w_hi_entry, w_word_end;
    logic [DIV_W-1:0] w_div;

    // Out-of-range indices decode to no active select.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (32'(idx) == 32'(i)) v[i] = 1'b0;
        return v;
    endfunction

    assign w_accept    = tx_valid && r_ready;
    assign w_bits_done = (r_bit == BIT_W'(DATA_W));
    assign w_hi_entry  = w_tick && ((r_state == SETUP) || (r_state == SCK_LO && !w_bits_done));
    assign w_word_end  = w_tick && (r_state == SCK_LO) && w_bits_done;
    assign w_div       = (r_state == IDLE) ? clk_div : r_div;

    always_comb begin
        w_load = 1'b0;
        case (r_state)
            IDLE:                                  w_load = w_accept;
            CS_OFF, SETUP, SCK_HI, SCK_LO, HOLD:   w_load = w_tick;
            default:                               w_load = 1'b0;
        endcase
    end

    spi_half_period_tick #(.DIV_W(DIV_W)) u_tick (
        .i_clk  (clk),
        .i_rst  (rst_in),
        .i_load (w_load),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state      <= PWR_RST;
            r_rst_cnt    <= '0;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_sclk       <= SCLK_IDLE;
            r_mosi       <= 1'b0;
            r_cs_n       <= '1;
            r_dc         <= 1'b0;
            r_disp_rst_n <= 1'b0;
            r_tx         <= '0;
            r_cs         <= '0;
            r_dc_q       <= 1'b0;
            r_last       <= 1'b0;
            r_div        <= '0;
            r_held       <= 1'b0;
            r_bit        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                PWR_RST: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state      <= PWR_WAIT;
                        r_rst_cnt    <= '0;
                        r_disp_rst_n <= 1'b1;
                    end else
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                PWR_WAIT: begin
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                end
                IDLE: begin
                    if (w_accept) begin
                        r_tx    <= tx_data;
                        r_cs    <= tx_cs;
                        r_dc_q  <= tx_dc;
                        r_last  <= tx_last;
                        r_div   <= clk_div;
                        r_bit   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        // A held select on another index must drop before the new one asserts.
                        if (r_held && tx_cs != r_cs) begin
                            r_state <= CS_OFF;
                            r_cs_n  <= '1;
                            r_held  <= 1'b0;
                        end else begin
                            r_state <= SETUP;
                            r_cs_n  <= cs_decode(tx_cs);
                            r_dc    <= tx_dc;
                            r_mosi  <= tx_data[DATA_W-1];
                        end
                    end
                end
                CS_OFF: begin
                    if (w_tick) begin
                        r_state <= SETUP;
                        r_cs_n  <= cs_decode(r_cs);
                        r_dc    <= r_dc_q;
                        r_mosi  <= r_tx[DATA_W-1];
                    end
                end
                SETUP: begin
                    if (w_hi_entry) begin
                        r_state <= SCK_HI;
                        r_sclk  <= ~SCLK_IDLE;
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                SCK_HI: begin
                    if (w_tick) begin
                        r_state <= SCK_LO;
                        r_sclk  <= SCLK_IDLE;
                        r_tx    <= {r_tx[DATA_W-2:0], 1'b0};
                        r_mosi  <= r_tx[DATA_W-2];
                    end
                end
                SCK_LO: begin
                    if (w_word_end) begin
                        r_done <= 1'b1;
                        if (r_last)
                            r_state <= HOLD;
                        else begin
                            r_state <= IDLE;
                            r_held  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_hi_entry) begin
                        r_state <= SCK_HI;
                        r_sclk  <= ~SCLK_IDLE;
                        r_bit   <= r_bit + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_cs_n  <= '1;
                        r_held  <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= PWR_RST;
            endcase
        end
    end

`ifdef SPI_RX_EN
    logic [DATA_W-1:0] r_rx_sh, r_rx_data;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_rx_sh   <= '0;
            r_rx_data <= '0;
        end else begin
            if (w_hi_entry)
                r_rx_sh <= {r_rx_sh[DATA_W-2:0], spi_miso};
            if (w_word_end)
                r_rx_data <= r_rx_sh;
        end
    end

    assign rx_data = r_rx_data;
`endif

    assign tx_ready   = r_ready;
    assign done       = r_done;
    assign busy       = r_busy;
    assign spi_sclk   = r_sclk;
    assign spi_mosi   = r_mosi;
    assign spi_cs_n   = r_cs_n;
    assign spi_dc     = r_dc;
    assign disp_rst_n = r_disp_rst_n;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: timeline model of each word plus directed and random words.
// Build with SPI_RX_EN defined to also check rx_data through a MOSI->MISO loopback.
module tb_spi_frame_ctrl;

    localparam int DW  = 8;
    localparam int NCS = 3;
    localparam int CW  = 2;
    localparam int RST = 16;

    logic           clk = 1'b0;
    logic           rst_in = 1'b1;
    logic [7:0]     clk_div = 8'd0;
    logic           tx_valid = 1'b0;
    logic           tx_ready;
    logic [DW-1:0]  tx_data = '0;
    logic [CW-1:0]  tx_cs = '0;
    logic           tx_dc = 1'b0;
    logic           tx_last = 1'b0;
    logic           done, busy, spi_sclk, spi_mosi, spi_dc, disp_rst_n;
    logic [NCS-1:0] spi_cs_n;
`ifdef SPI_RX_EN
    logic [DW-1:0]  rx_data;
    logic           spi_miso;
    assign spi_miso = spi_mosi;
`endif

    spi_frame_ctrl #(
        .DATA_W(DW), .NUM_CS(NCS), .CS_W(CW), .DIV_W(8), .RST_CYCLES(RST)
    ) dut (
        .clk(clk), .rst_in(rst_in), .clk_div(clk_div),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_cs(tx_cs), .tx_dc(tx_dc), .tx_last(tx_last),
        .done(done), .busy(busy), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .disp_rst_n(disp_rst_n)
`ifdef SPI_RX_EN
        , .spi_miso(spi_miso), .rx_data(rx_data)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        n_tot++;
        $display("FAIL %s: timed out", nm);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic           sclk;
        logic [NCS-1:0] csn;
        logic           ready, busy, done, disp;
        logic           mosi_v, mosi, dc_v, dc;
    } exp_t;

    int            cyc = 0;
    int            m_ref = 0;
    int            m_h = 1;
    int            m_gap = 0;
    bit            m_pwr = 1'b1;
    bit            m_last = 1'b1;
    bit            m_dc = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [CW-1:0] m_cs = '0;
    bit            started = 1'b0;

    function automatic logic [NCS-1:0] dec(input logic [CW-1:0] cs);
        logic [NCS-1:0] v;
        for (int i = 0; i < NCS; i++) v[i] = (int'(cs) != i);
        return v;
    endfunction

    // Expected outputs p cycles after the last reset edge or word-accept edge.
    function automatic exp_t model(input int p);
        exp_t e;
        int   h, q, r, j;
        e      = '0;
        e.csn  = '1;
        e.disp = 1'b1;
        if (m_pwr) begin
            e.disp  = (p >= RST);
            e.ready = (p >= 2 * RST);
            e.busy  = !e.ready;
            return e;
        end
        h      = m_h;
        e.busy = 1'b1;
        if (p < m_gap) return e;
        q = p - m_gap;
        if (q < h) begin
            e.csn = dec(m_cs);
            e.mosi_v = 1'b1; e.mosi = m_data[DW-1];
            e.dc_v = 1'b1;   e.dc = m_dc;
            return e;
        end
        r = q - h;
        if (r < 2 * DW * h) begin
            j      = r / h;
            e.csn  = dec(m_cs);
            e.sclk = (j % 2 == 0);
            e.dc_v = 1'b1; e.dc = m_dc;
            if (j % 2 == 0) begin
                e.mosi_v = 1'b1; e.mosi = m_data[DW-1-j/2];
            end else if (j / 2 < DW - 1) begin
                e.mosi_v = 1'b1; e.mosi = m_data[DW-2-j/2];
            end
            return e;
        end
        e.done = (r == 2 * DW * h);
        if (m_last && r < (2 * DW + 1) * h) begin
            e.csn = dec(m_cs);
            return e;
        end
        e.ready = 1'b1;
        e.busy  = 1'b0;
        if (!m_last) e.csn = dec(m_cs);
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t pe;
        bit   held;
        pe = model(cyc - m_ref);
        cyc++;
        if (rst_in) begin
            m_pwr   = 1'b1;
            m_ref   = cyc;
            started = 1'b1;
        end else if (tx_valid && pe.ready) begin
            held   = !m_pwr && !m_last;
            m_gap  = (held && m_cs != tx_cs) ? int'(clk_div) + 1 : 0;
            m_pwr  = 1'b0;
            m_ref  = cyc;
            m_data = tx_data;
            m_cs   = tx_cs;
            m_dc   = tx_dc;
            m_last = tx_last;
            m_h    = int'(clk_div) + 1;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        exp_t ce;
        if (started) begin
            ce = model(cyc - m_ref);
            chk("sclk", 32'(spi_sclk), 32'(ce.sclk));
            chk("cs_n", 32'(spi_cs_n), 32'(ce.csn));
            chk("tx_ready", 32'(tx_ready), 32'(ce.ready));
            chk("busy", 32'(busy), 32'(ce.busy));
            chk("done", 32'(done), 32'(ce.done));
            chk("disp_rst_n", 32'(disp_rst_n), 32'(ce.disp));
            if (ce.mosi_v) chk("mosi", 32'(spi_mosi), 32'(ce.mosi));
            if (ce.dc_v)   chk("dc", 32'(spi_dc), 32'(ce.dc));
`ifdef SPI_RX_EN
            if (ce.done)   chk("rx_data", 32'(rx_data), 32'(m_data));
`endif
        end
    end

    // ---------------- event counters for directed checks ----------------
    int             rise_cnt, done_cnt, allhi_cnt, cslow_cnt, rel_cnt, dlo_cnt, dhi_cnt;
    int             period, last_rise;
    logic [31:0]    mosi_cap;
    logic [DW-1:0]  rx_cap = '0;
    bit             prev_sclk = 1'b0;
    logic [NCS-1:0] prev_csn = '1;

    always @(negedge clk) begin
        if (spi_sclk && !prev_sclk) begin
            rise_cnt++;
            mosi_cap  = {mosi_cap[30:0], spi_mosi};
            period    = cyc - last_rise;
            last_rise = cyc;
        end
        prev_sclk = spi_sclk;
        if (done === 1'b1) begin
            done_cnt++;
`ifdef SPI_RX_EN
            rx_cap = rx_data;
`endif
        end
        if (spi_cs_n === '1) allhi_cnt++; else cslow_cnt++;
        if (|(~prev_csn & spi_cs_n)) rel_cnt++;
        prev_csn = spi_cs_n;
        if (disp_rst_n === 1'b0) dlo_cnt++;
        else if (tx_ready === 1'b0) dhi_cnt++;
    end

    task automatic clr();
        rise_cnt = 0; done_cnt = 0; allhi_cnt = 0; cslow_cnt = 0; rel_cnt = 0;
        dlo_cnt = 0; dhi_cnt = 0; period = 0; mosi_cap = '0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] cs,
                        input logic dc, input logic last, input logic [7:0] div);
        exp_t se;
        int   n;
        n = 0;
        @(negedge clk);
        se = model(cyc - m_ref);
        while (!se.ready && n < 10000) begin
            @(negedge clk);
            se = model(cyc - m_ref);
            n++;
        end
        tx_data = d; tx_cs = cs; tx_dc = dc; tx_last = last; clk_div = div;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        clk_div  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 10000);
        if (done !== 1'b1) tmo(nm);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_ready !== 1'b1 && n < 10000);
        if (tx_ready !== 1'b1) tmo(nm);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: power-up sequence; a word offered during PWR_* must be ignored
        clr();
        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        clr();
        tx_data = 8'h55; tx_cs = 2'd0; tx_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle("pwr_ready");
        @(posedge clk); #1;
        chk("pwr_low_cycles", dlo_cnt, 16);
        chk("pwr_wait_cycles", dhi_cnt, 16);
        chk("pwr_sclk_rises", rise_cnt, 0);
        chk("pwr_cs_low_cycles", cslow_cnt, 0);
        chk("pwr_ready", 32'(tx_ready), 1);

        // 2: single word 0xA5 on cs1, div=1
        clr();
        send(8'hA5, 2'd1, 1'b1, 1'b1, 8'd1);
        wait_idle("t2_idle");
        @(posedge clk); #1;
        chk("t2_mosi_bits", mosi_cap[7:0], 8'hA5);
        chk("t2_rises", rise_cnt, 8);
        chk("t2_sclk_period", period, 4);
        chk("t2_done_pulses", done_cnt, 1);
        chk("t2_cs_low_cycles", cslow_cnt, 36);
        chk("t2_cs_after", 32'(spi_cs_n), 3'b111);

        // 3: burst on the same select, div=0
        clr();
        send(8'h12, 2'd0, 1'b0, 1'b0, 8'd0);
        send(8'h34, 2'd0, 1'b1, 1'b1, 8'd0);
        wait_idle("t3_idle");
        @(posedge clk); #1;
        chk("t3_rises", rise_cnt, 16);
        chk("t3_done_pulses", done_cnt, 2);
        chk("t3_mosi_bits", mosi_cap[15:0], 16'h1234);
        chk("t3_cs_releases", rel_cnt, 1);
        chk("t3_sclk_period", period, 2);

        // 4: held cs0 then a word on cs1 -> one half-period gap
        send(8'hC3, 2'd0, 1'b1, 1'b0, 8'd2);
        wait_done("t4_done_a");
        @(posedge clk); #1;
        clr();
        send(8'h5A, 2'd1, 1'b0, 1'b1, 8'd2);
        wait_done("t4_done_b");
        @(posedge clk); #1;
        chk("t4_gap_cycles", allhi_cnt, 3);
        chk("t4_cs_releases", rel_cnt, 1);
        wait_idle("t4_idle");

        // 5: reset in the middle of a word
        clr();
        send(8'hF0, 2'd1, 1'b1, 1'b1, 8'd1);
        begin
            int n;
            n = 0;
            while (rise_cnt < 3 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (rise_cnt < 3) tmo("t5_rises");
        end
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        chk("t5_cs_n", 32'(spi_cs_n), 3'b111);
        chk("t5_sclk", 32'(spi_sclk), 0);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_disp", 32'(disp_rst_n), 0);
        wait_idle("t5_idle");
        @(posedge clk); #1;
        chk("t5_no_done", done_cnt, 0);

`ifdef SPI_RX_EN
        // 6: loopback receive
        clr();
        send(8'h3C, 2'd0, 1'b0, 1'b1, 8'd2);
        wait_done("t6_done");
        @(posedge clk); #1;
        chk("t6_rx_data", 32'(rx_cap), 8'h3C);
        wait_idle("t6_idle");
`endif

        // Maximum divider and out-of-range select
        clr();
        send(8'h81, 2'd3, 1'b0, 1'b1, 8'hFF);
        wait_idle("max_div_idle");
        @(posedge clk); #1;
        chk("max_div_period", period, 512);
        chk("max_div_mosi", mosi_cap[7:0], 8'h81);
        chk("oob_cs_low_cycles", cslow_cnt, 0);
        chk("oob_done_pulses", done_cnt, 1);

        // Random words checked by the model
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 3)));
        end
        wait_idle("rand_idle");
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
